// File: rtl/axi_rd_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// axi_rd_arbiter_pkg
// Shared constants and types for the two-way AXI read arbiter:
//   - fixed AXI burst attributes driven on every request
//   - FSM state encoding (IDLE -> AR -> R -> IDLE)
//   - grant encoding (0 = icache, 1 = dcache)
// -----------------------------------------------------------------------------
package axi_rd_arbiter_pkg;

  localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_AR   = 2'd1,
    ARB_R    = 2'd2
  } arb_state_t;

  localparam logic GNT_I = 1'b0;
  localparam logic GNT_D = 1'b1;

endpackage

// File: rtl/axi_rd_arbiter_rr_arb2.sv
// -----------------------------------------------------------------------------
// rr_arb2
// Two-way round-robin picker. Purely combinational.
// Ports:
//   i_req_i  icache request
//   i_req_d  dcache request
//   i_prio   requester that wins a tie (GNT_I / GNT_D)
//   o_any    at least one request present
//   o_gnt    selected requester (only meaningful when o_any = 1)
// -----------------------------------------------------------------------------
module rr_arb2
  import axi_rd_arbiter_pkg::*;
(
  input  logic i_req_i,
  input  logic i_req_d,
  input  logic i_prio,
  output logic o_any,
  output logic o_gnt
);

  assign o_any = i_req_i | i_req_d;

  always_comb begin
    o_gnt = GNT_I;
    if (i_req_i && i_req_d) begin
      o_gnt = i_prio;
    end else if (i_req_d) begin
      o_gnt = GNT_D;
    end
  end

endmodule

// File: rtl/axi_rd_arbiter.sv
// -----------------------------------------------------------------------------
// axi_rd_arbiter
// Shares one AXI4 read channel (AR + R) between icache and dcache. One burst is
// outstanding at a time; ties in IDLE are broken round-robin.
//
// Handshake semantics: every channel transfers on the cycle where valid and
// ready are both high; a source holds valid and its payload stable until that
// cycle, and ready may be driven combinationally from the other side's valid.
//
// Ports:
//   clk, rstn                       clock, synchronous active-low reset
//   i_ar*, i_r*                     icache AR request / R beat delivery
//   d_ar*, d_r*                     dcache AR request / R beat delivery
//   arvalid..arid, arready          AXI read-address master
//   rvalid, rlast, rdata, rid, rready  AXI read-data master
//   o_state                         FSM state (debug)
//   o_gnt                           current grant, 0 = icache, 1 = dcache (debug)
// -----------------------------------------------------------------------------
module axi_rd_arbiter
  import axi_rd_arbiter_pkg::*;
#(
  parameter int          ADDR_W = 32,
  parameter int          DATA_W = 32,
  parameter logic [3:0]  ID_I   = 4'd0,
  parameter logic [3:0]  ID_D   = 4'd1
) (
  input  logic              clk,
  input  logic              rstn,
  // icache
  input  logic              i_arvalid,
  input  logic [ADDR_W-1:0] i_araddr,
  input  logic [7:0]        i_arlen,
  output logic              i_arready,
  output logic              i_rvalid,
  output logic              i_rlast,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              i_rready,
  // dcache
  input  logic              d_arvalid,
  input  logic [ADDR_W-1:0] d_araddr,
  input  logic [7:0]        d_arlen,
  output logic              d_arready,
  output logic              d_rvalid,
  output logic              d_rlast,
  output logic [DATA_W-1:0] d_rdata,
  input  logic              d_rready,
  // AXI AR
  output logic              arvalid,
  output logic [ADDR_W-1:0] araddr,
  output logic [7:0]        arlen,
  output logic [2:0]        arsize,
  output logic [1:0]        arburst,
  output logic [3:0]        arid,
  input  logic              arready,
  // AXI R
  input  logic              rvalid,
  input  logic              rlast,
  input  logic [DATA_W-1:0] rdata,
  input  logic [3:0]        rid,
  output logic              rready,
  // debug
  output logic [1:0]        o_state,
  output logic              o_gnt
);

  arb_state_t        r_state;
  arb_state_t        w_state_nxt;
  logic              r_prio;
  logic              r_gnt;
  logic [ADDR_W-1:0] r_araddr;
  logic [7:0]        r_arlen;
  logic [3:0]        r_arid;

  logic              w_any;
  logic              w_pick;
  logic              w_latch;
  logic              w_in_r;
  logic              w_done;
  logic              w_unused;

  // With a single burst in flight the ID carries no routing information.
  assign w_unused = ^rid;

  rr_arb2 u_rr_arb2 (
    .i_req_i (i_arvalid),
    .i_req_d (d_arvalid),
    .i_prio  (r_prio),
    .o_any   (w_any),
    .o_gnt   (w_pick)
  );

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_latch     = 1'b0;
    case (r_state)
      ARB_IDLE: begin
        if (w_any) begin
          w_state_nxt = ARB_AR;
          w_latch     = 1'b1;
        end
      end
      ARB_AR: begin
        if (arready) begin
          w_state_nxt = ARB_R;
        end
      end
      ARB_R: begin
        if (w_done) begin
          w_state_nxt = ARB_IDLE;
        end
      end
      default: begin
        w_state_nxt = ARB_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State and AR payload registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state  <= ARB_IDLE;
      r_prio   <= GNT_D;
      r_gnt    <= GNT_I;
      r_araddr <= '0;
      r_arlen  <= '0;
      r_arid   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_latch) begin
        r_gnt    <= w_pick;
        r_araddr <= (w_pick == GNT_D) ? d_araddr : i_araddr;
        r_arlen  <= (w_pick == GNT_D) ? d_arlen  : i_arlen;
        r_arid   <= (w_pick == GNT_D) ? ID_D     : ID_I;
      end
      // The requester that just finished loses the next tie.
      if (w_done) begin
        r_prio <= ~r_gnt;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // AR channel
  // ---------------------------------------------------------------------------
  assign arvalid = (r_state == ARB_AR);
  assign araddr  = r_araddr;
  assign arlen   = r_arlen;
  assign arid    = r_arid;
  assign arsize  = AXI_SIZE_4B;
  assign arburst = AXI_BURST_INCR;

  // The requester's ready is only the slave's handshake passed through.
  assign i_arready = arvalid && arready && (r_gnt == GNT_I);
  assign d_arready = arvalid && arready && (r_gnt == GNT_D);

  // ---------------------------------------------------------------------------
  // R channel: beats outside R are neither accepted nor forwarded.
  // ---------------------------------------------------------------------------
  assign w_in_r = (r_state == ARB_R);
  assign rready = w_in_r && ((r_gnt == GNT_D) ? d_rready : i_rready);
  assign w_done = w_in_r && rvalid && rready && rlast;

  assign i_rvalid = w_in_r && (r_gnt == GNT_I) && rvalid;
  assign i_rlast  = w_in_r && (r_gnt == GNT_I) && rlast;
  assign d_rvalid = w_in_r && (r_gnt == GNT_D) && rvalid;
  assign d_rlast  = w_in_r && (r_gnt == GNT_D) && rlast;
  assign i_rdata  = rdata;
  assign d_rdata  = rdata;

  assign o_state = r_state;
  assign o_gnt   = r_gnt;

endmodule

// File: tb/tb_axi_rd_arbiter.sv
module tb_axi_rd_arbiter;
  import axi_rd_arbiter_pkg::*;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk;
  logic rstn;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic        i_arvalid, i_arready, i_rvalid, i_rlast, i_rready;
  logic [31:0] i_araddr, i_rdata;
  logic [7:0]  i_arlen;
  logic        d_arvalid, d_arready, d_rvalid, d_rlast, d_rready;
  logic [31:0] d_araddr, d_rdata;
  logic [7:0]  d_arlen;
  logic        arvalid, arready, rvalid, rlast, rready;
  logic [31:0] araddr, rdata;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic [3:0]  arid, rid;
  logic [1:0]  o_state;
  logic        o_gnt;

  axi_rd_arbiter dut (
    .clk       (clk),
    .rstn      (rstn),
    .i_arvalid (i_arvalid),
    .i_araddr  (i_araddr),
    .i_arlen   (i_arlen),
    .i_arready (i_arready),
    .i_rvalid  (i_rvalid),
    .i_rlast   (i_rlast),
    .i_rdata   (i_rdata),
    .i_rready  (i_rready),
    .d_arvalid (d_arvalid),
    .d_araddr  (d_araddr),
    .d_arlen   (d_arlen),
    .d_arready (d_arready),
    .d_rvalid  (d_rvalid),
    .d_rlast   (d_rlast),
    .d_rdata   (d_rdata),
    .d_rready  (d_rready),
    .arvalid   (arvalid),
    .araddr    (araddr),
    .arlen     (arlen),
    .arsize    (arsize),
    .arburst   (arburst),
    .arid      (arid),
    .arready   (arready),
    .rvalid    (rvalid),
    .rlast     (rlast),
    .rdata     (rdata),
    .rid       (rid),
    .rready    (rready),
    .o_state   (o_state),
    .o_gnt     (o_gnt)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  logic [31:0] exp_q[$];
  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next active edge, where inputs are driven.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------------------------------------------------------------------
  // Driver: serves one burst from the slave side. Called at posedge+1 of the
  // IDLE cycle in which the requester's arvalid is already driven. Returns at
  // posedge+1 of the IDLE cycle following the rlast handshake.
  // ---------------------------------------------------------------------------
  task automatic serve(input bit is_d, input logic [31:0] addr, input logic [7:0] len,
                       input logic [3:0] id, input int ar_wait, input bit toggle,
                       input bit stray);
    int   lat;
    bit   seen;
    bit   acc;
    bit   tg;
    logic rr;
    logic [31:0] e;
    lat  = 0;
    seen = 0;
    tg   = 0;
    arready = (ar_wait == 0);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (arvalid) begin
        seen = 1;
        break;
      end
      tick();
      lat++;
    end
    check("ar_seen", 64'(seen), 64'd1);
    if (!seen) return;
    check("ar_latency", 64'(lat), 64'd1);
    check("araddr", araddr, addr);
    check("arlen", arlen, len);
    check("arid", arid, id);
    check("arsize", arsize, 3'b010);
    check("arburst", arburst, 2'b01);
    if (ar_wait > 0) begin
      check("ar_hold_i_arready", i_arready, 1'b0);
      check("ar_hold_d_arready", d_arready, 1'b0);
      for (int k = 1; k < ar_wait; k++) begin
        tick();
        if (stray) begin
          rvalid = 1'b1;
          rdata  = $urandom;
        end
        @(negedge clk);
        check("ar_hold_arvalid", arvalid, 1'b1);
        check("ar_hold_araddr", araddr, addr);
        check("ar_hold_arlen", arlen, len);
        check("ar_hold_arready", {i_arready, d_arready}, 2'b00);
        if (stray) begin
          check("stray_rready", rready, 1'b0);
          check("stray_rvalid", {i_rvalid, d_rvalid}, 2'b00);
        end
      end
      tick();
      rvalid  = 1'b0;
      arready = 1'b1;
      @(negedge clk);
    end
    check("ar_hs_arvalid", arvalid, 1'b1);
    check("ar_hs_grant", {d_arready, i_arready}, is_d ? 2'b10 : 2'b01);
    tick();
    arready = 1'b0;
    if (is_d) d_arvalid = 1'b0;
    else      i_arvalid = 1'b0;

    for (int b = 0; b <= int'(len); b++) begin
      rvalid = 1'b1;
      rdata  = $urandom;
      rlast  = (b == int'(len));
      rid    = id;
      exp_q.push_back(rdata);
      acc = 0;
      for (int c = 0; c < 4 && !acc; c++) begin
        rr = toggle ? tg : 1'b1;
        tg = ~tg;
        if (is_d) d_rready = rr;
        else      i_rready = rr;
        @(negedge clk);
        check("r_arvalid", arvalid, 1'b0);
        check("r_rready", rready, rr);
        check("r_arready_held", {i_arready, d_arready}, 2'b00);
        if (is_d) begin
          check("r_d_rvalid", d_rvalid, 1'b1);
          check("r_d_rlast", d_rlast, rlast);
          check("r_i_quiet", {i_rvalid, i_rlast}, 2'b00);
        end else begin
          check("r_i_rvalid", i_rvalid, 1'b1);
          check("r_i_rlast", i_rlast, rlast);
          check("r_d_quiet", {d_rvalid, d_rlast}, 2'b00);
        end
        if (rr) begin
          acc = 1;
          e = exp_q.pop_front();
          check("r_data", is_d ? d_rdata : i_rdata, e);
        end
        tick();
      end
      if (!acc) check("beat_timeout", 64'd0, 64'd1);
    end
    rvalid   = 1'b0;
    rlast    = 1'b0;
    i_rready = 1'b1;
    d_rready = 1'b1;
    #1;
    check("end_state_idle", o_state, ARB_IDLE);
    check("end_rready", rready, 1'b0);
    check("end_queue_empty", 64'(exp_q.size()), 64'd0);
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    rstn = 1'b0;
    i_arvalid = 0; i_araddr = '0; i_arlen = '0; i_rready = 1'b1;
    d_arvalid = 0; d_araddr = '0; d_arlen = '0; d_rready = 1'b1;
    arready = 0; rvalid = 0; rlast = 0; rdata = '0; rid = '0;
    repeat (3) tick();
    @(negedge clk);
    check("rst_arvalid", arvalid, 1'b0);
    check("rst_rready", rready, 1'b0);
    check("rst_araddr", araddr, 32'd0);
    check("rst_arlen", arlen, 8'd0);
    check("rst_arid", arid, 4'd0);
    check("rst_arready", {i_arready, d_arready}, 2'b00);
    check("rst_rvalid", {i_rvalid, d_rvalid}, 2'b00);
    check("rst_rlast", {i_rlast, d_rlast}, 2'b00);
    check("rst_state", o_state, ARB_IDLE);
    tick();
    rstn = 1'b1;
    tick();

    // Icache only, 4 beats, slave arready already high.
    i_araddr = 32'h1C00_0010; i_arlen = 8'd3; i_arvalid = 1'b1;
    serve(1'b0, 32'h1C00_0010, 8'd3, 4'd0, 0, 1'b0, 1'b0);

    // Contended: D first, then I, then D again, then I drains.
    i_araddr = 32'h1C00_0200; i_arlen = 8'd3; i_arvalid = 1'b1;
    d_araddr = 32'h8000_1000; d_arlen = 8'd3; d_arvalid = 1'b1;
    serve(1'b1, 32'h8000_1000, 8'd3, 4'd1, 0, 1'b0, 1'b0);
    serve(1'b0, 32'h1C00_0200, 8'd3, 4'd0, 0, 1'b0, 1'b0);
    i_araddr = 32'h1C00_0300; i_arlen = 8'd1; i_arvalid = 1'b1;
    d_araddr = 32'h8000_2000; d_arlen = 8'd2; d_arvalid = 1'b1;
    serve(1'b1, 32'h8000_2000, 8'd2, 4'd1, 0, 1'b0, 1'b0);
    serve(1'b0, 32'h1C00_0300, 8'd1, 4'd0, 0, 1'b0, 1'b0);

    // Slave stalls AR for 5 cycles with a stray R beat offered meanwhile.
    d_araddr = 32'h8000_3000; d_arlen = 8'd1; d_arvalid = 1'b1;
    serve(1'b1, 32'h8000_3000, 8'd1, 4'd1, 5, 1'b0, 1'b1);

    // Icache throttles R with i_rready toggling.
    i_araddr = 32'h1C00_0400; i_arlen = 8'd3; i_arvalid = 1'b1;
    serve(1'b0, 32'h1C00_0400, 8'd3, 4'd0, 0, 1'b1, 1'b0);

    // Uncached 2-beat icache burst; arvalid dropped right after handshake.
    i_araddr = 32'h1C00_0500; i_arlen = 8'd1; i_arvalid = 1'b1;
    serve(1'b0, 32'h1C00_0500, 8'd1, 4'd0, 0, 1'b0, 1'b0);

    // Single-beat dcache burst.
    d_araddr = 32'h8000_4000; d_arlen = 8'd0; d_arvalid = 1'b1;
    serve(1'b1, 32'h8000_4000, 8'd0, 4'd1, 0, 1'b0, 1'b0);

    // Reset during beat 2 of a D burst.
    d_araddr = 32'h8000_5000; d_arlen = 8'd3; d_arvalid = 1'b1;
    arready = 1'b1;
    tick();
    tick();
    arready = 1'b0; d_arvalid = 1'b0;
    rvalid = 1'b1; rdata = $urandom; rlast = 1'b0; rid = 4'd1;
    @(negedge clk);
    check("rst_mid_beat1", d_rvalid, 1'b1);
    tick();
    rdata = $urandom;
    rstn  = 1'b0;
    tick();
    @(negedge clk);
    check("rst_mid_state", o_state, ARB_IDLE);
    check("rst_mid_arvalid", arvalid, 1'b0);
    check("rst_mid_rready", rready, 1'b0);
    check("rst_mid_araddr", araddr, 32'd0);
    check("rst_mid_arlen", arlen, 8'd0);
    check("rst_mid_arid", arid, 4'd0);
    check("rst_mid_rvalid", {i_rvalid, d_rvalid}, 2'b00);
    check("rst_mid_rlast", {i_rlast, d_rlast}, 2'b00);
    tick();
    rstn = 1'b1; rvalid = 1'b0;
    i_araddr = 32'h1C00_0600; i_arlen = 8'd1; i_arvalid = 1'b1;
    serve(1'b0, 32'h1C00_0600, 8'd1, 4'd0, 0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
